// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the oversampling UART receiver.
package uart_rx_pkg;

  localparam int DEFAULT_DATA_WIDTH = 8;

  localparam logic [5:0] PRESCALE_8  = 6'd8;
  localparam logic [5:0] PRESCALE_16 = 6'd16;
  localparam logic [5:0] PRESCALE_32 = 6'd32;

  typedef enum logic {
    EVEN = 1'b0,
    ODD  = 1'b1
  } parity_t;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } rx_state_t;

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  // A prescale of 0 is stretched to 64 so a bit period never exceeds 64 cycles.
  function automatic logic [6:0] eff_prescale(input logic [5:0] p);
    return (p == 6'd0) ? 7'd64 : {1'b0, p};
  endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Serial input, frame configuration and received-byte outputs of the UART receiver.
interface uart_rx_if
  import uart_rx_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) ();

  logic                  RX_IN;
  logic [5:0]            PRESCALE;
  logic                  PAR_EN;
  logic                  PAR_TYP;
  logic [DATA_WIDTH-1:0] P_DATA;
  logic                  DATA_VALID;
  logic                  PAR_ERR;
  logic                  STP_ERR;

  modport master (
    output RX_IN, PRESCALE, PAR_EN, PAR_TYP,
    input  P_DATA, DATA_VALID, PAR_ERR, STP_ERR
  );

  modport slave (
    input  RX_IN, PRESCALE, PAR_EN, PAR_TYP,
    output P_DATA, DATA_VALID, PAR_ERR, STP_ERR
  );

endinterface

// File: rtl/uart_rx_sampler.sv
// Per-bit oversampling counter with a 2-of-3 majority vote around the bit centre.
module uart_rx_sampler
  import uart_rx_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       run,
  input  logic [5:0] prescale,
  input  logic       rx,
  output logic       sampled_bit,
  output logic       sample_done,
  output logic       bit_end
);

  logic [6:0] edge_cnt;
  logic [6:0] p_eff;
  logic [6:0] half;
  logic [6:0] last_cnt;
  logic       smp_a;
  logic       smp_b;

  assign p_eff       = eff_prescale(prescale);
  assign half        = p_eff >> 1;
  assign last_cnt    = p_eff - 7'd1;
  assign sample_done = (edge_cnt == (half + 7'd2));
  // >= keeps the counter bounded even if the period shrinks under it.
  assign bit_end     = (edge_cnt >= last_cnt);

  // Position within the current bit period; held at zero while not running.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      edge_cnt <= 7'd0;
    end else if (!run || bit_end) begin
      edge_cnt <= 7'd0;
    end else begin
      edge_cnt <= edge_cnt + 7'd1;
    end
  end

  // Capture three centre samples; the vote is registered on the third.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      smp_a       <= 1'b1;
      smp_b       <= 1'b1;
      sampled_bit <= 1'b1;
    end else begin
      if (edge_cnt == (half - 7'd1)) begin
        smp_a <= rx;
      end
      if (edge_cnt == half) begin
        smp_b <= rx;
      end
      if (edge_cnt == (half + 7'd1)) begin
        sampled_bit <= majority3(smp_a, smp_b, rx);
      end
    end
  end

endmodule

// File: rtl/uart_rx.sv
// UART receiver top: line synchronizer, frame FSM, deserializer, parity check
// and registered result strobes.
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input logic       CLK,
  input logic       RST,
  uart_rx_if.slave  bus
);

  localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CW-1:0] BIT_LAST = CW'(DATA_WIDTH - 1);

  logic                  rx_meta;
  logic                  rx_s;
  rx_state_t             state,        state_next;
  logic [CW-1:0]         bit_cnt,      bit_cnt_next;
  logic [DATA_WIDTH-1:0] shift,        shift_next;
  logic [DATA_WIDTH-1:0] p_data,       p_data_next;
  logic [5:0]            prescale_lat, prescale_next;
  logic                  par_en_lat,   par_en_next;
  parity_t               par_typ_lat,  par_typ_next;
  logic                  par_flag,     par_flag_next;
  logic                  data_valid,   data_valid_next;
  logic                  par_err,      par_err_next;
  logic                  stp_err,      stp_err_next;
  logic [5:0]            prescale_cur;
  logic                  run;
  logic                  sampled_bit;
  logic                  sample_done;
  logic                  bit_end;

  // Two-flop synchronizer for the asynchronous serial line; idles high.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= bus.RX_IN;
      rx_s    <= rx_meta;
    end
  end

  // Live prescale only matters on the start-detect cycle; afterwards the frame uses the latched copy.
  assign prescale_cur = (state == IDLE) ? bus.PRESCALE : prescale_lat;
  assign run          = (state_next != IDLE);

  uart_rx_sampler u_sampler (
    .clk         (CLK),
    .rst         (RST),
    .run         (run),
    .prescale    (prescale_cur),
    .rx          (rx_s),
    .sampled_bit (sampled_bit),
    .sample_done (sample_done),
    .bit_end     (bit_end)
  );

  // State, datapath and output registers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state        <= IDLE;
      bit_cnt      <= '0;
      shift        <= '0;
      p_data       <= '0;
      prescale_lat <= PRESCALE_16;
      par_en_lat   <= 1'b0;
      par_typ_lat  <= EVEN;
      par_flag     <= 1'b0;
      data_valid   <= 1'b0;
      par_err      <= 1'b0;
      stp_err      <= 1'b0;
    end else begin
      state        <= state_next;
      bit_cnt      <= bit_cnt_next;
      shift        <= shift_next;
      p_data       <= p_data_next;
      prescale_lat <= prescale_next;
      par_en_lat   <= par_en_next;
      par_typ_lat  <= par_typ_next;
      par_flag     <= par_flag_next;
      data_valid   <= data_valid_next;
      par_err      <= par_err_next;
      stp_err      <= stp_err_next;
    end
  end

  // Next-state and datapath decisions for the frame FSM.
  always_comb begin
    state_next      = state;
    bit_cnt_next    = bit_cnt;
    shift_next      = shift;
    p_data_next     = p_data;
    prescale_next   = prescale_lat;
    par_en_next     = par_en_lat;
    par_typ_next    = par_typ_lat;
    par_flag_next   = par_flag;
    data_valid_next = 1'b0;
    par_err_next    = 1'b0;
    stp_err_next    = 1'b0;

    case (state)
      IDLE: begin
        if (!rx_s) begin
          state_next    = START;
          bit_cnt_next  = '0;
          par_flag_next = 1'b0;
          prescale_next = bus.PRESCALE;
          par_en_next   = bus.PAR_EN;
          par_typ_next  = parity_t'(bus.PAR_TYP);
        end else begin
          state_next = IDLE;
        end
      end

      START: begin
        if (sample_done && sampled_bit) begin
          state_next = IDLE;
        end else if (bit_end) begin
          state_next   = DATA;
          bit_cnt_next = '0;
        end else begin
          state_next = START;
        end
      end

      DATA: begin
        if (sample_done) begin
          shift_next = {sampled_bit, shift[DATA_WIDTH-1:1]};
        end else begin
          shift_next = shift;
        end
        if (bit_end && (bit_cnt == BIT_LAST)) begin
          state_next   = par_en_lat ? PARITY : STOP;
          bit_cnt_next = '0;
        end else if (bit_end) begin
          bit_cnt_next = bit_cnt + CW'(1);
        end else begin
          bit_cnt_next = bit_cnt;
        end
      end

      PARITY: begin
        if (sample_done) begin
          par_flag_next = sampled_bit ^ (^shift) ^ (par_typ_lat == ODD);
        end else begin
          par_flag_next = par_flag;
        end
        if (bit_end) begin
          state_next = STOP;
        end else begin
          state_next = PARITY;
        end
      end

      // bit_end is a fallback that only fires first for unsupported prescales.
      STOP: begin
        if (sample_done || bit_end) begin
          state_next   = IDLE;
          stp_err_next = ~sampled_bit;
          par_err_next = par_flag;
          if (sampled_bit && !par_flag) begin
            data_valid_next = 1'b1;
            p_data_next     = shift;
          end else begin
            data_valid_next = 1'b0;
          end
        end else begin
          state_next = STOP;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign bus.P_DATA     = p_data;
  assign bus.DATA_VALID = data_valid;
  assign bus.PAR_ERR    = par_err;
  assign bus.STP_ERR    = stp_err;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: frames are pushed to a scoreboard as they are driven
// and checked against each result strobe, including its arrival cycle.
module tb_uart_rx;
  import uart_rx_pkg::*;

  typedef struct {
    logic       dv;
    logic       pe;
    logic       se;
    logic [7:0] data;
    int         cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  bit   ignore = 1'b0;
  logic [7:0] model_pdata = 8'h00;
  logic [7:0] prev_pdata  = 8'h00;
  exp_t sb[$];

  uart_rx_if #(.DATA_WIDTH(8)) bus ();

  uart_rx #(.DATA_WIDTH(8)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard consumer: every strobe must match the oldest outstanding frame.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && !ignore) begin
      chk("pdata_hold", 32'(bus.DATA_VALID !== 1'b1 && bus.P_DATA !== prev_pdata), 32'd0);
      if (bus.DATA_VALID || bus.PAR_ERR || bus.STP_ERR) begin
        chk("strobe_expected", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk("strobe_cycle", 32'(cyc), 32'(e.cyc));
          chk("data_valid", 32'(bus.DATA_VALID), 32'(e.dv));
          chk("par_err", 32'(bus.PAR_ERR), 32'(e.pe));
          chk("stp_err", 32'(bus.STP_ERR), 32'(e.se));
          chk("p_data", 32'(bus.P_DATA), 32'(e.data));
        end
      end
    end
    prev_pdata = bus.P_DATA;
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive_bit(input logic v, input int p, input bit glitch);
    for (int j = 0; j < p; j++) begin
      bus.RX_IN = (glitch && j == p / 2) ? ~v : v;
      @(negedge clk);
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input int p, input logic pen, input logic ptyp,
                            input logic par_flip, input logic stop_v, input int glitch_bit);
    exp_t e;
    bus.PRESCALE = 6'(p);
    bus.PAR_EN   = pen;
    bus.PAR_TYP  = ptyp;
    e.se = ~stop_v;
    e.pe = pen & par_flip;
    e.dv = ~e.se & ~e.pe;
    if (e.dv) model_pdata = d;
    e.data = model_pdata;
    // 2 synchronizer cycles, decision cycle counted from the first rx_s-low cycle, +1 output register.
    e.cyc = cyc + 2 + (1 + 8 + int'(pen)) * p + p / 2 + 2 + 1;
    sb.push_back(e);
    drive_bit(1'b0, p, 1'b0);
    bus.PRESCALE = 6'd13;
    bus.PAR_EN   = ~pen;
    bus.PAR_TYP  = ~ptyp;
    for (int i = 0; i < 8; i++) drive_bit(d[i], p, glitch_bit == i);
    if (pen) drive_bit((^d) ^ ptyp ^ par_flip, p, 1'b0);
    drive_bit(stop_v, p, 1'b0);
    bus.RX_IN = 1'b1;
  endtask

  initial begin
    bus.RX_IN    = 1'b1;
    bus.PRESCALE = PRESCALE_8;
    bus.PAR_EN   = 1'b0;
    bus.PAR_TYP  = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", 32'({bus.P_DATA, bus.DATA_VALID, bus.PAR_ERR, bus.STP_ERR}), 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      chk("idle_outputs", 32'({bus.P_DATA, bus.DATA_VALID, bus.PAR_ERR, bus.STP_ERR}), 32'd0);
    end

    send_frame(8'h55, 16, 1'b1, EVEN, 1'b0, 1'b1, -1);
    send_frame(8'h93, 16, 1'b1, ODD,  1'b0, 1'b1, -1);
    idle(20);
    send_frame(8'hAA, 8,  1'b0, EVEN, 1'b0, 1'b1, -1);
    send_frame(8'h77, 32, 1'b0, EVEN, 1'b0, 1'b1, -1);
    idle(20);

    send_frame(8'h55, 16, 1'b1, EVEN, 1'b1, 1'b1, -1);
    idle(20);
    send_frame(8'h55, 16, 1'b1, EVEN, 1'b0, 1'b0, -1);
    idle(40);
    send_frame(8'hA5, 16, 1'b1, ODD,  1'b1, 1'b0, -1);
    idle(40);

    bus.PRESCALE = PRESCALE_16;
    bus.RX_IN = 1'b0;
    idle(3);
    bus.RX_IN = 1'b1;
    idle(40);
    send_frame(8'h3C, 16, 1'b0, EVEN, 1'b0, 1'b1, -1);
    idle(10);
    send_frame(8'hE1, 16, 1'b1, EVEN, 1'b0, 1'b1, 2);
    send_frame(8'h0F, 8,  1'b0, EVEN, 1'b0, 1'b1, 5);
    idle(20);

    // Unsupported prescale: results are unspecified, but the receiver must recover.
    ignore = 1'b1;
    bus.PRESCALE = 6'd1;
    bus.RX_IN = 1'b0;
    idle(20);
    bus.RX_IN = 1'b1;
    idle(11 * 64);
    ignore = 1'b0;
    idle(2);
    send_frame(8'h5A, 8, 1'b1, ODD, 1'b0, 1'b1, -1);
    idle(20);

    bus.PRESCALE = PRESCALE_16;
    bus.PAR_EN   = 1'b0;
    drive_bit(1'b0, 16, 1'b0);
    drive_bit(1'b1, 16, 1'b0);
    drive_bit(1'b0, 16, 1'b0);
    drive_bit(1'b1, 8, 1'b0);
    rst = 1'b1;
    #1;
    chk("reset_mid_frame", 32'({bus.P_DATA, bus.DATA_VALID, bus.PAR_ERR, bus.STP_ERR}), 32'd0);
    bus.RX_IN = 1'b1;
    @(negedge clk);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_pdata = 8'h00;
    idle(30);
    send_frame(8'hC3, 16, 1'b1, EVEN, 1'b0, 1'b1, -1);

    for (int i = 0; i < 300 && sb.size() != 0; i++) @(negedge clk);
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
